// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - cook-timer MM:SS capture, BCD to 7-seg decode, 4-digit scan
// Registered outputs: one dead-time cycle per slot, leading-zero blanking, blinking colon.
module seg7_scan_decoder #(
  parameter int REFRESH_DIV  = 4,
  parameter int BLINK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic        enable,
  input  logic        blank_lead,
  input  logic        colon_blink,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [15:0]   shadow;
  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [FW-1:0] frame;
  logic          colon_phase;

  logic [3:0] nib;
  logic       blank;
  logic       active;

  // Non-BCD nibbles show a dash so a corrupted timer value is visible.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h7E;
      4'd1:    decode = 7'h30;
      4'd2:    decode = 7'h6D;
      4'd3:    decode = 7'h79;
      4'd4:    decode = 7'h33;
      4'd5:    decode = 7'h5B;
      4'd6:    decode = 7'h5F;
      4'd7:    decode = 7'h70;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h7B;
      default: decode = 7'h01;
    endcase
  endfunction

  always_comb begin
    nib = shadow[3:0];
    case (slot)
      2'd0: nib = shadow[3:0];
      2'd1: nib = shadow[7:4];
      2'd2: nib = shadow[11:8];
      2'd3: nib = shadow[15:12];
      default: nib = shadow[3:0];
    endcase

    // A slot blanks only while every more-significant digit is also zero.
    blank = 1'b0;
    if (blank_lead) begin
      case (slot)
        2'd3:    blank = (shadow[15:12] == 4'd0);
        2'd2:    blank = (shadow[15:8] == 8'd0);
        2'd1:    blank = (shadow[15:4] == 12'd0);
        default: blank = 1'b0;
      endcase
    end

    active = enable && (cnt != '0) && !blank;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= 16'h0000;
      cnt         <= '0;
      slot        <= 2'd0;
      frame       <= '0;
      colon_phase <= 1'b1;
      seg         <= 7'd0;
      an          <= 4'd0;
      dp          <= 1'b0;
    end else begin
      if (load) shadow <= digits_in;

      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        slot <= slot + 2'd1;
        if (slot == 2'd3) begin
          if (frame == FRAME_LAST) begin
            frame       <= '0;
            colon_phase <= ~colon_phase;
          end else begin
            frame <= frame + 1'b1;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Outputs reflect the pre-edge scan position and shadow.
      an  <= active ? (4'b0001 << slot) : 4'd0;
      seg <= active ? decode(nib) : 7'd0;
      dp  <= active && (slot == 2'd2) && (!colon_blink || colon_phase);
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed checks of scan, decode, blanking, colon and reset
module tb_seg7_scan_decoder;

  localparam int REFRESH_DIV  = 4;
  localparam int BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lead = 1'b0;
  logic        colon_blink = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [6:0] tbl [4];
  logic [3:0] mask;

  seg7_scan_decoder #(.REFRESH_DIV(REFRESH_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load), .enable(enable),
    .blank_lead(blank_lead), .colon_blink(colon_blink), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_tbl(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                         input logic [6:0] s0, input logic [3:0] m);
    tbl[3] = s3; tbl[2] = s2; tbl[1] = s1; tbl[0] = s0;
    mask = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected {seg,an,dp} for the edge whose pre-edge scan position is cyc.
  task automatic step(input string tag);
    int c, s, f;
    logic [11:0] e;
    c = cyc % REFRESH_DIV;
    s = (cyc / REFRESH_DIV) % 4;
    f = cyc / (REFRESH_DIV * 4);
    e = '0;
    if (enable && c != 0 && !mask[s]) begin
      e[11:5] = tbl[s];
      e[4:1]  = 4'b0001 << s;
      e[0]    = (s == 2) && (!colon_blink || ((f / BLINK_FRAMES) % 2) == 0);
    end
    tick();
    check(tag, {4'h0, seg, an, dp}, {4'h0, e});
  endtask

  task automatic load_digits(input logic [15:0] d);
    digits_in = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic align();
    while (cyc % (REFRESH_DIV * 4) != 0) tick();
  endtask

  task automatic frames(input string tag, input int n);
    for (int i = 0; i < n * REFRESH_DIV * 4; i++) step(tag);
  endtask

  initial begin
    set_tbl(7'h00, 7'h00, 7'h00, 7'h00, 4'h0);
    #17;
    check("reset_out", {4'h0, seg, an, dp}, 16'h0000);
    rst_n = 1'b1;
    cyc = 0;

    // 1234, no blanking, steady colon
    enable = 1'b1;
    load_digits(16'h1234);
    set_tbl(7'h30, 7'h6D, 7'h79, 7'h33, 4'b0000);
    align();
    frames("scan_1234", 1);

    // load latency across a slot boundary
    for (int i = 0; i < 7; i++) step("pre_load");
    digits_in = 16'h5678;
    load = 1'b1;
    step("load_edge_old");
    load = 1'b0;
    set_tbl(7'h5B, 7'h5F, 7'h70, 7'h7F, 4'b0000);
    for (int i = 0; i < 8; i++) step("load_new");

    // 0005 with and without leading-zero blanking
    blank_lead = 1'b1;
    load_digits(16'h0005);
    set_tbl(7'h7E, 7'h7E, 7'h7E, 7'h5B, 4'b1110);
    align();
    frames("blank_0005", 1);
    blank_lead = 1'b0;
    set_tbl(7'h7E, 7'h7E, 7'h7E, 7'h5B, 4'b0000);
    frames("noblank_0005", 1);

    // 0107: only min tens dark, inner zero kept
    blank_lead = 1'b1;
    load_digits(16'h0107);
    set_tbl(7'h7E, 7'h30, 7'h7E, 7'h70, 4'b1000);
    align();
    frames("blank_0107", 1);

    // blinking colon over several frames
    colon_blink = 1'b1;
    load_digits(16'h1200);
    set_tbl(7'h30, 7'h6D, 7'h7E, 7'h7E, 4'b0000);
    align();
    frames("blink_1200", 6);
    colon_blink = 1'b0;

    // invalid BCD shows dash and is never blanked
    load_digits(16'h00AF);
    set_tbl(7'h7E, 7'h7E, 7'h01, 7'h01, 4'b1100);
    align();
    frames("dash_00af", 1);

    // async reset while slot 2 is lit
    blank_lead = 1'b0;
    load_digits(16'h1234);
    set_tbl(7'h30, 7'h6D, 7'h79, 7'h33, 4'b0000);
    align();
    for (int i = 0; i < 10; i++) step("pre_reset");
    check("an_before_reset", {12'h0, an}, 16'h0004);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {4'h0, seg, an, dp}, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_held", {4'h0, seg, an, dp}, 16'h0000);
    rst_n = 1'b1;
    cyc = 0;

    // shadow cleared by reset: 0000 without blanking shows zeros
    set_tbl(7'h7E, 7'h7E, 7'h7E, 7'h7E, 4'b0000);
    for (int i = 0; i < 16; i++) step("post_reset");

    // drop and restore enable mid-frame
    load_digits(16'h1234);
    set_tbl(7'h30, 7'h6D, 7'h79, 7'h33, 4'b0000);
    align();
    for (int i = 0; i < 6; i++) step("en_on");
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step("en_off");
    enable = 1'b1;
    for (int i = 0; i < 6; i++) step("en_resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
